// File: rtl/cronometro_ctrl.sv
// Countdown timer controller: BCD hh:mm:ss preset, run/pause/clear and a self-clearing
// alarm, with registered outputs feeding the text generator.
module cronometro_ctrl #(
  parameter int unsigned ALARM_TICKS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       cfg_we,
  input  logic [7:0] cfg_hora,
  input  logic [7:0] cfg_min,
  input  logic [7:0] cfg_seg,
  input  logic       start,
  input  logic       stop,
  input  logic       ack,
  output logic [7:0] R_Cronometro_Hora,
  output logic [7:0] R_Cronometro_Minutos,
  output logic [7:0] R_Cronometro_Segundo,
  output logic       alarma,
  output logic       running
);

  localparam logic [7:0] AlarmTicks = 8'(ALARM_TICKS);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StAlarm} state_e;

  state_e     state_q, state_d;
  logic [7:0] hora_q, hora_d, min_q, min_d, seg_q, seg_d;
  logic [7:0] alarm_cnt_q, alarm_cnt_d;
  logic       running_q, running_d, alarma_q, alarma_d;

  logic       preset_ok, count_nonzero;
  logic [7:0] hora_dec, min_dec, seg_dec;

  // 00 wraps to 59; callers only use the wrap on minutes and seconds.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v == 8'h00)          return 8'h59;
    else if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                     return v - 8'd1;
  endfunction

  always_comb begin
    preset_ok = (cfg_hora[3:0] <= 4'd9) && (cfg_min[3:0] <= 4'd9) && (cfg_seg[3:0] <= 4'd9) &&
                (cfg_min[7:4] <= 4'd5) && (cfg_seg[7:4] <= 4'd5) && (cfg_hora <= 8'h23);
    count_nonzero = (hora_q != 8'h00) || (min_q != 8'h00) || (seg_q != 8'h00);

    seg_dec  = bcd_dec(seg_q);
    min_dec  = (seg_q == 8'h00) ? bcd_dec(min_q) : min_q;
    hora_dec = ((seg_q == 8'h00) && (min_q == 8'h00)) ? bcd_dec(hora_q) : hora_q;
  end

  always_comb begin
    state_d     = state_q;
    hora_d      = hora_q;
    min_d       = min_q;
    seg_d       = seg_q;
    alarm_cnt_d = alarm_cnt_q;

    unique case (state_q)
      StIdle: begin
        // A strobe with an illegal preset is swallowed whole, so start is still blocked.
        if (cfg_we) begin
          if (preset_ok) begin
            hora_d = cfg_hora;
            min_d  = cfg_min;
            seg_d  = cfg_seg;
          end
        end else if (start && !stop && count_nonzero) begin
          state_d = StRun;
        end
      end
      StPause: begin
        if (cfg_we) begin
          if (preset_ok) begin
            hora_d  = cfg_hora;
            min_d   = cfg_min;
            seg_d   = cfg_seg;
            state_d = StIdle;
          end
        end else if (stop) begin
          hora_d  = 8'h00;
          min_d   = 8'h00;
          seg_d   = 8'h00;
          state_d = StIdle;
        end else if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (stop) begin
          state_d = StPause;
        end else if (tick_1hz) begin
          hora_d = hora_dec;
          min_d  = min_dec;
          seg_d  = seg_dec;
          if ({hora_dec, min_dec, seg_dec} == 24'h000000) begin
            state_d     = StAlarm;
            alarm_cnt_d = 8'd0;
          end
        end
      end
      StAlarm: begin
        hora_d = 8'h00;
        min_d  = 8'h00;
        seg_d  = 8'h00;
        if (ack) begin
          state_d = StIdle;
        end else if (tick_1hz) begin
          alarm_cnt_d = alarm_cnt_q + 8'd1;
          if (alarm_cnt_q + 8'd1 == AlarmTicks) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    running_d = (state_d == StRun);
    alarma_d  = (state_d == StAlarm);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      hora_q      <= 8'h00;
      min_q       <= 8'h00;
      seg_q       <= 8'h00;
      alarm_cnt_q <= 8'd0;
      running_q   <= 1'b0;
      alarma_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hora_q      <= hora_d;
      min_q       <= min_d;
      seg_q       <= seg_d;
      alarm_cnt_q <= alarm_cnt_d;
      running_q   <= running_d;
      alarma_q    <= alarma_d;
    end
  end

  assign R_Cronometro_Hora    = hora_q;
  assign R_Cronometro_Minutos = min_q;
  assign R_Cronometro_Segundo = seg_q;
  assign alarma               = alarma_q;
  assign running              = running_q;

endmodule
